// File: rtl/ms_ff_bank_if.sv
// ms_ff_bank_if: control/data bundle for ms_ff_bank; ERR_CNT exists only with MS_FF_BANK_ERRCNT_EN
interface ms_ff_bank_if #(parameter int WIDTH = 4);
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             CLR_ERR;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             ERR;
`ifdef MS_FF_BANK_ERRCNT_EN
  logic [7:0]       ERR_CNT;
`endif
  modport master (
    output EN, MODE, S, R, CLR_ERR,
    input  Y, Q, Qbar, ERR
`ifdef MS_FF_BANK_ERRCNT_EN
    , input ERR_CNT
`endif
  );
  modport slave (
    input  EN, MODE, S, R, CLR_ERR,
    output Y, Q, Qbar, ERR
`ifdef MS_FF_BANK_ERRCNT_EN
    , output ERR_CNT
`endif
  );
endinterface

// File: rtl/ms_ff_bank.sv
// ms_ff_bank: bank of master-slave SR/JK/D/T flip-flops; MS_FF_BANK_ERRCNT_EN adds a saturating forbidden-input counter
module ms_ff_bank #(parameter int WIDTH = 4) (
  input logic         C,
  input logic         RST,
  ms_ff_bank_if.slave b
);
  logic [WIDTH-1:0] y_q, y_d, q_q, sr, jk;
  logic             err_q, err_d, forb;
  // next master value is derived from the slave so a toggle happens once per period
  always_comb begin
    sr    = (b.S & ~b.R) | (q_q & ~(b.S ^ b.R));
    jk    = (b.S & ~q_q) | (~b.R & q_q);
    y_d   = !b.EN ? y_q : b.MODE == 2'b00 ? sr : b.MODE == 2'b01 ? jk : b.MODE == 2'b10 ? b.S : q_q ^ b.S;
    forb  = b.EN && b.MODE == 2'b00 && |(b.S & b.R);
    err_d = forb | (err_q & ~b.CLR_ERR);
  end
  // master stage and error flag capture on the rising edge
  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      err_q <= err_d;
    end
  end
  // slave stage follows the master on the falling edge
  always_ff @(negedge C or posedge RST) begin
    if (RST) q_q <= '0;
    else q_q <= y_q;
  end
`ifdef MS_FF_BANK_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  // one count per forbidden edge, saturating; a clear still records a coincident event
  always_comb begin
    cnt_d = b.CLR_ERR ? {7'd0, forb} : cnt_q + {7'd0, forb && cnt_q != 8'hFF};
  end
  // counter register
  always_ff @(posedge C or posedge RST) begin
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign b.ERR_CNT = cnt_q;
`endif
  assign b.Y    = y_q;
  assign b.Q    = q_q;
  assign b.Qbar = ~q_q;
  assign b.ERR  = err_q;
endmodule

// File: doc/ms_ff_bank.md
MS_FF_BANK -- requirements
Module: ms_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent master-slave flip-flop bits (1..32).
REQ-002 C  input  1  clock; master captures on rising edge, slave transfers on falling edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 EN  input  1  capture enable; sampled at rising edge of C.
REQ-005 MODE  input  2  bank mode: 00 SR, 01 JK, 10 D (S is data), 11 T (S is toggle); R is ignored in modes 10/11.
REQ-006 S  input  WIDTH  set / J / D / T input, one bit per flip-flop.
REQ-007 R  input  WIDTH  reset / K input, one bit per flip-flop.
REQ-008 CLR_ERR  input  1  synchronous clear of error status, sampled at rising edge of C.
REQ-009 Y  output  WIDTH  master stage state.
REQ-010 Q  output  WIDTH  slave stage state.
REQ-011 Qbar  output  WIDTH  bitwise complement of Q, combinational, never equal to Q.
REQ-012 ERR  output  1  sticky forbidden-input flag.
REQ-013 ERR_CNT  output  8  forbidden-input event counter (present only per REQ-030).

Function
REQ-014 At rising edge of C with EN=1, each Y[i] SHALL load next(Q[i],S[i],R[i],MODE); with EN=0, Y holds.
REQ-015 At falling edge of C, Q SHALL load Y; Q never changes at a rising edge except via RST.
REQ-016 SR mode per bit: 00 hold, 10 set, 01 clear, 11 forbidden -> hold Q[i].
REQ-017 JK mode per bit: 00 hold, 10 set, 01 clear, 11 toggle (~Q[i]).
REQ-018 D mode: Y[i] = S[i]; T mode: Y[i] = Q[i] XOR S[i].
REQ-019 Next-state SHALL be computed from Q (slave), never from Y, so toggle occurs exactly once per clock period regardless of how long C is high.
REQ-020 MODE, S, R, EN, CLR_ERR are sampled only at rising edge; changes while C is high or low SHALL not affect Y or Q until the next rising edge.
REQ-021 Forbidden event: rising edge with EN=1, MODE=00, and (S AND R) nonzero; bits not forbidden update normally in the same edge.
REQ-022 ERR SHALL set on a forbidden event and hold until CLR_ERR=1 or RST.
REQ-023 CLR_ERR and a forbidden event at the same edge: ERR SHALL end at 1 (set wins).
REQ-024 Forbidden events with EN=0 or MODE other than 00 SHALL not set ERR.
REQ-025 Mode change between edges SHALL not alter stored Y/Q; the new mode applies from the next rising edge using the current Q.

Reset
REQ-026 RST=1 SHALL immediately, independent of C, force Y=0, Q=0, Qbar=all ones, ERR=0, ERR_CNT=0.
REQ-027 While RST=1, all edges of C SHALL be ignored.
REQ-028 RST asserted between a rising and falling edge SHALL discard the captured master value; after release Q stays 0 until a new rising-then-falling edge pair.
REQ-029 RST deassertion SHALL not itself cause any capture; the first capture is the first rising edge of C with RST=0.

Configuration
REQ-030 Macro MS_FF_BANK_ERRCNT_EN: when defined, ERR_CNT exists and increments by 1 per forbidden event (one per edge regardless of how many bits), saturating at 255; CLR_ERR clears it, and with a simultaneous forbidden event it SHALL read 1 afterwards.
REQ-031 Without MS_FF_BANK_ERRCNT_EN, port ERR_CNT and its counter SHALL be absent; all other behaviour is identical.

Verification (WIDTH=4, period 40 ns)
REQ-032 RST pulse mid-high-phase after Y=1111 -> Y=0000, Q=0000, Qbar=1111 immediately; next falling edge leaves Q=0000.
REQ-033 SR mode, S=0101 R=0000, EN=1 -> Y=0101 after rising edge, Q unchanged until falling edge, then Q=0101, Qbar=1010.
REQ-034 JK mode from Q=0101, S=R=1111 held four periods -> Q sequence 1010, 0101, 1010, 0101, exactly one toggle per period.
REQ-035 SR mode from Q=0011, S=1001 R=0001 -> Q=1011, ERR=1, ERR_CNT=1; same inputs with EN=0 -> no change to ERR/ERR_CNT.
REQ-036 300 consecutive forbidden edges -> ERR_CNT=255 saturated; then CLR_ERR=1 with forbidden inputs -> ERR=1, ERR_CNT=1; CLR_ERR=1 with S=R=0 -> ERR=0, ERR_CNT=0.
REQ-037 T mode, S=0001, EN toggled 1,0,1 across three periods from Q=0000 -> Q=0001, 0001, 0000.
